// File: rtl/melody_sequencer.sv
// melody_sequencer: walks the song ROM from address 0, loads each note's
// duration into the shared timer, holds the note's pitch for the tone
// generator until the timer expires, then inserts a short silent gap before
// fetching the next note. Playback stops at an end marker (dur == 0) or at
// the top of the address space, or wraps to address 0 when looping.
module melody_sequencer #(
    parameter int ADDR_W     = 8,
    parameter int PITCH_W    = 8,
    parameter int DUR_W      = 16,
    parameter int TICK_SCALE = 100000,
    parameter int GAP_CYCLES = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic                     stop_i,
    input  logic                     loop_i,
    output logic [ADDR_W-1:0]        rom_addr_o,
    input  logic [PITCH_W+DUR_W-1:0] rom_data_i,
    output logic                     timer_en_o,
    output logic [31:0]              timer_value_o,
    input  logic                     timeup_i,
    output logic [PITCH_W-1:0]       pitch_o,
    output logic                     note_strobe_o,
    output logic                     playing_o,
    output logic                     done_o
);

    // The gap counter counts down from GAP_CYCLES-1 to 0, so it only needs
    // enough bits to hold GAP_CYCLES-1 (at least one bit).
    localparam int                GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0]  GAP_LOAD = GAP_W'(GAP_CYCLES - 1);
    localparam logic [31:0]       TICK     = 32'(TICK_SCALE);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        PLAY,
        GAP,
        DONE
    } state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   romAddr_q;
    logic                timerEn_q;
    logic [31:0]         timerValue_q;
    logic [PITCH_W-1:0]  pitch_q;
    logic                noteStrobe_q;
    logic                playing_q;
    logic                done_q;
    logic [GAP_W-1:0]    gapCount_q;

    logic [PITCH_W-1:0]  romPitch;
    logic [DUR_W-1:0]    romDur;

    assign romPitch = rom_data_i[PITCH_W+DUR_W-1 -: PITCH_W];
    assign romDur   = rom_data_i[DUR_W-1:0];

    assign rom_addr_o    = romAddr_q;
    assign timer_en_o    = timerEn_q;
    assign timer_value_o = timerValue_q;
    assign pitch_o       = pitch_q;
    assign note_strobe_o = noteStrobe_q;
    assign playing_o     = playing_q;
    assign done_o        = done_q;

    // Sequencer FSM. Every output is a register updated alongside the state,
    // so nothing combinational reaches the ports. Reset and stop share the
    // same clearing path; the timer samples timer_value one edge after it is
    // loaded here, since both are registered at the LOAD->PLAY transition.
    always_ff @(posedge clk_i) begin
        if (rst_i || stop_i) begin
            state_q      <= IDLE;
            romAddr_q    <= '0;
            timerEn_q    <= 1'b0;
            timerValue_q <= '0;
            pitch_q      <= '0;
            noteStrobe_q <= 1'b0;
            playing_q    <= 1'b0;
            done_q       <= 1'b0;
            gapCount_q   <= '0;
        end else begin
            noteStrobe_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_q   <= FETCH;
                        romAddr_q <= '0;
                        playing_q <= 1'b1;
                    end
                end
                FETCH: begin
                    state_q <= LOAD;
                end
                LOAD: begin
                    if (romDur == '0) begin
                        if (loop_i) begin
                            state_q   <= FETCH;
                            romAddr_q <= '0;
                        end else begin
                            state_q   <= DONE;
                            playing_q <= 1'b0;
                            done_q    <= 1'b1;
                        end
                    end else begin
                        state_q      <= PLAY;
                        timerValue_q <= 32'(romDur) * TICK;
                        pitch_q      <= romPitch;
                        timerEn_q    <= 1'b1;
                        noteStrobe_q <= 1'b1;
                    end
                end
                PLAY: begin
                    if (timeup_i) begin
                        state_q    <= GAP;
                        timerEn_q  <= 1'b0;
                        pitch_q    <= '0;
                        gapCount_q <= GAP_LOAD;
                    end
                end
                GAP: begin
                    if (gapCount_q == '0) begin
                        if (romAddr_q == '1) begin
                            if (loop_i) begin
                                state_q   <= FETCH;
                                romAddr_q <= '0;
                            end else begin
                                state_q   <= DONE;
                                playing_q <= 1'b0;
                                done_q    <= 1'b1;
                            end
                        end else begin
                            state_q   <= FETCH;
                            romAddr_q <= romAddr_q + 1'b1;
                        end
                    end else begin
                        gapCount_q <= gapCount_q - 1'b1;
                    end
                end
                DONE: begin
                    if (start_i) begin
                        state_q   <= FETCH;
                        romAddr_q <= '0;
                        done_q    <= 1'b0;
                        playing_q <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    timerEn_q <= 1'b0;
                    pitch_q   <= '0;
                    playing_q <= 1'b0;
                    done_q    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_melody_sequencer.sv
// tb_melody_sequencer: drives melody_sequencer with a small song ROM and a
// behavioural timer. Expected notes are queued when a song is started and
// popped whenever the sequencer strobes a new note.
module tb_melody_sequencer;

    localparam int ADDR_W     = 2;
    localparam int PITCH_W    = 8;
    localparam int DUR_W      = 16;
    localparam int TICK_SCALE = 10;
    localparam int GAP_CYCLES = 2;
    localparam int ROM_W      = PITCH_W + DUR_W;
    localparam int ROM_DEPTH  = 4;

    typedef struct {
        logic [PITCH_W-1:0] pitch;
        logic [31:0]        value;
        logic [ADDR_W-1:0]  addr;
    } note_t;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                start = 1'b0;
    logic                stop = 1'b0;
    logic                loopEn = 1'b0;
    logic                timeupForce = 1'b0;
    logic [ADDR_W-1:0]   romAddr;
    logic [ROM_W-1:0]    romData = '0;
    logic                timerEn;
    logic [31:0]         timerValue;
    logic                timeup;
    logic [PITCH_W-1:0]  pitch;
    logic                noteStrobe;
    logic                playing;
    logic                done;

    logic [ROM_W-1:0]    rom [ROM_DEPTH];
    logic [31:0]         timerCount = '0;

    int                  vectors = 0;
    int                  miscompares = 0;
    int                  strobeTotal = 0;
    int                  lowCount = 0;
    int                  base = 0;
    bit                  gapCheckEn = 1'b0;
    bit                  sawNote = 1'b0;
    bit                  prevEn = 1'b0;
    bit                  doneSeen = 1'b0;
    note_t               expQ[$];

    melody_sequencer #(
        .ADDR_W(ADDR_W),
        .PITCH_W(PITCH_W),
        .DUR_W(DUR_W),
        .TICK_SCALE(TICK_SCALE),
        .GAP_CYCLES(GAP_CYCLES)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .start_i(start),
        .stop_i(stop),
        .loop_i(loopEn),
        .rom_addr_o(romAddr),
        .rom_data_i(romData),
        .timer_en_o(timerEn),
        .timer_value_o(timerValue),
        .timeup_i(timeup),
        .pitch_o(pitch),
        .note_strobe_o(noteStrobe),
        .playing_o(playing),
        .done_o(done)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Synchronous song ROM: data follows the address by one clock.
    always @(posedge clk) romData <= rom[romAddr];

    // Behavioural timer: counts while enabled, clears when disabled, and
    // raises timeup on the value-th enabled cycle.
    always @(posedge clk) begin
        if (!timerEn) timerCount <= '0;
        else          timerCount <= timerCount + 32'd1;
    end
    assign timeup = (timerEn && (timerCount == timerValue - 32'd1)) || timeupForce;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Per-cycle observation: scoreboard pop on each note strobe, measurement
    // of the timer_en low stretch between notes, and DONE tracking.
    task automatic sample();
        note_t e;
        if (noteStrobe) begin
            strobeTotal++;
            if (expQ.size() == 0) begin
                checkOutput("strobe_expected", 32'(expQ.size()), 32'd1);
            end else begin
                e = expQ.pop_front();
                checkOutput("note_pitch", 32'(pitch), 32'(e.pitch));
                checkOutput("note_value", timerValue, e.value);
                checkOutput("note_addr", 32'(romAddr), 32'(e.addr));
            end
        end
        if (timerEn) begin
            if (!prevEn && sawNote && gapCheckEn)
                checkOutput("gap_len", 32'(lowCount), 32'(GAP_CYCLES + 2));
            sawNote  = gapCheckEn;
            lowCount = 0;
        end else begin
            lowCount++;
        end
        if (!gapCheckEn) sawNote = 1'b0;
        prevEn = timerEn;
        if (done) doneSeen = 1'b1;
    endtask

    task automatic tick();
        @(negedge clk);
        sample();
    endtask

    // Drive a one-cycle pulse on the selected inputs.
    task automatic applyStimulus(input logic s, input logic p, input logic r, input logic f);
        start = s;
        stop = p;
        rst = r;
        timeupForce = f;
        tick();
        start = 1'b0;
        stop = 1'b0;
        rst = 1'b0;
        timeupForce = 1'b0;
    endtask

    task automatic expectNote(input int a);
        note_t e;
        logic [ROM_W-1:0] w;
        w = rom[a];
        e.pitch = w[ROM_W-1 -: PITCH_W];
        e.value = 32'(w[DUR_W-1:0]) * 32'(TICK_SCALE);
        e.addr  = ADDR_W'(a);
        expQ.push_back(e);
    endtask

    task automatic loadSongA();
        rom[0] = {8'h3C, 16'd3};
        rom[1] = {8'h40, 16'd2};
        rom[2] = {8'h00, 16'd0};
        rom[3] = {8'h55, 16'd1};
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_addr"}, 32'(romAddr), 32'd0);
        checkOutput({tag, "_en"}, 32'(timerEn), 32'd0);
        checkOutput({tag, "_value"}, timerValue, 32'd0);
        checkOutput({tag, "_pitch"}, 32'(pitch), 32'd0);
        checkOutput({tag, "_strobe"}, 32'(noteStrobe), 32'd0);
        checkOutput({tag, "_playing"}, 32'(playing), 32'd0);
        checkOutput({tag, "_done"}, 32'(done), 32'd0);
    endtask

    task automatic waitDone(input int budget, input string tag);
        int n = 0;
        while (!done && n < budget) begin
            tick();
            n++;
        end
        checkOutput(tag, 32'(done), 32'd1);
    endtask

    task automatic waitStrobes(input int target, input int budget, input string tag);
        int n = 0;
        while (strobeTotal < target && n < budget) begin
            tick();
            n++;
        end
        checkOutput(tag, 32'(strobeTotal >= target), 32'd1);
    endtask

    task automatic waitEnFall(input int budget, input string tag);
        int n = 0;
        while (timerEn && n < budget) begin
            tick();
            n++;
        end
        checkOutput(tag, 32'(timerEn), 32'd0);
    endtask

    task automatic waitTimeup(input int budget, input string tag);
        int n = 0;
        while (!timeup && n < budget) begin
            tick();
            n++;
        end
        checkOutput(tag, 32'(timeup), 32'd1);
    endtask

    initial begin
        loadSongA();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checkAllZero("reset");

        // Two notes then end marker, no loop.
        $display("[TB] two-note song, no loop");
        loopEn = 1'b0;
        gapCheckEn = 1'b1;
        expectNote(0);
        expectNote(1);
        base = strobeTotal;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("s1_fetch_playing", 32'(playing), 32'd1);
        checkOutput("s1_fetch_en", 32'(timerEn), 32'd0);
        tick();
        checkOutput("s1_load_en", 32'(timerEn), 32'd0);
        tick();
        checkOutput("s1_play_strobe", 32'(noteStrobe), 32'd1);
        checkOutput("s1_play_en", 32'(timerEn), 32'd1);
        waitDone(400, "s1_done");
        checkOutput("s1_strobes", 32'(strobeTotal - base), 32'd2);
        checkOutput("s1_done_pitch", 32'(pitch), 32'd0);
        checkOutput("s1_done_playing", 32'(playing), 32'd0);
        checkOutput("s1_queue", 32'(expQ.size()), 32'd0);
        gapCheckEn = 1'b0;

        // Same song looping: the first note replays and DONE never shows.
        $display("[TB] two-note song, looping");
        loopEn = 1'b1;
        expectNote(0);
        expectNote(1);
        expectNote(0);
        base = strobeTotal;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        doneSeen = 1'b0;
        waitStrobes(base + 3, 400, "s2_replay");
        checkOutput("s2_done_seen", 32'(doneSeen), 32'd0);
        checkOutput("s2_queue", 32'(expQ.size()), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("s2_stop_playing", 32'(playing), 32'd0);
        checkOutput("s2_stop_en", 32'(timerEn), 32'd0);
        loopEn = 1'b0;

        // Full ROM without marker, including a rest: stops at the top address.
        $display("[TB] full ROM, no marker");
        rom[0] = {8'h11, 16'd1};
        rom[1] = {8'h22, 16'd2};
        rom[2] = {8'h00, 16'd1};
        rom[3] = {8'h44, 16'd1};
        for (int a = 0; a < ROM_DEPTH; a++) expectNote(a);
        base = strobeTotal;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        waitDone(400, "s3_done");
        checkOutput("s3_strobes", 32'(strobeTotal - base), 32'd4);
        checkOutput("s3_done_addr", 32'(romAddr), 32'd3);
        checkOutput("s3_queue", 32'(expQ.size()), 32'd0);

        // Stop coinciding with timeup must land in IDLE, not GAP.
        $display("[TB] stop together with timeup");
        loadSongA();
        expectNote(0);
        base = strobeTotal;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        waitStrobes(base + 1, 20, "s4_note");
        waitTimeup(100, "s4_timeup");
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("s4_playing", 32'(playing), 32'd0);
        checkOutput("s4_en", 32'(timerEn), 32'd0);
        checkOutput("s4_pitch", 32'(pitch), 32'd0);
        checkOutput("s4_addr", 32'(romAddr), 32'd0);
        for (int i = 0; i < 6; i++) tick();
        checkOutput("s4_no_more_notes", 32'(strobeTotal - base), 32'd1);

        // Reset in the gap after note 2, then replay from the start.
        $display("[TB] reset mid-gap");
        expectNote(0);
        expectNote(1);
        base = strobeTotal;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        waitStrobes(base + 2, 200, "s5_second_note");
        waitEnFall(100, "s5_gap");
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkAllZero("s5_reset");
        expectNote(0);
        expectNote(1);
        base = strobeTotal;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        waitDone(400, "s5_done");
        checkOutput("s5_strobes", 32'(strobeTotal - base), 32'd2);

        // Start during PLAY and stray timeup in GAP/IDLE are ignored.
        $display("[TB] ignored start and timeup");
        expectNote(0);
        expectNote(1);
        base = strobeTotal;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        waitStrobes(base + 1, 20, "s6_note");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("s6_start_en", 32'(timerEn), 32'd1);
        checkOutput("s6_start_pitch", 32'(pitch), 32'h3C);
        checkOutput("s6_start_strobe", 32'(noteStrobe), 32'd0);
        waitEnFall(100, "s6_gap");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("s6_gap_en", 32'(timerEn), 32'd0);
        checkOutput("s6_gap_playing", 32'(playing), 32'd1);
        tick();
        tick();
        tick();
        checkOutput("s6_next_strobe", 32'(noteStrobe), 32'd1);
        waitDone(200, "s6_done");
        checkOutput("s6_strobes", 32'(strobeTotal - base), 32'd2);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        base = strobeTotal;
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("s6_idle_playing", 32'(playing), 32'd0);
        checkOutput("s6_idle_en", 32'(timerEn), 32'd0);
        checkOutput("s6_idle_strobes", 32'(strobeTotal - base), 32'd0);
        checkOutput("s6_queue", 32'(expQ.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
